// File: rtl/hci_package.sv
// Shared types for the HWPE split interconnect.
// Holds the split FSM state encoding and the lane-mask type.
// Lane masks are sized for the widest supported wide port; unused upper bits stay 0.
package hci_package;

  // Split controller states: accept/issue a wide request, then gather bank responses.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } split_state_e;

  // Upper bound on 32-bit lanes per wide port (1024-bit wide port).
  localparam int HCI_MAX_LANES = 32;

  typedef logic [HCI_MAX_LANES-1:0] lane_mask_t;

endpackage

// File: rtl/hci_intf.sv
// HCI interface bundles used by the split interconnect.
// hci_core_intf: wide HWPE-side port (req/gnt request phase, r_valid response phase).
// hci_mem_intf : 32-bit bank-side port with the same handshake.
interface hci_core_intf #(
  parameter int DW = 128,
  parameter int AW = 32
) ();
  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   data;
  logic [DW-1:0]   r_data;
  logic            r_valid;
  logic            r_user;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid, r_user);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid, r_user);
endinterface

interface hci_mem_intf #(
  parameter int DW = 32,
  parameter int AW = 14
) ();
  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   data;
  logic            user;
  logic [DW-1:0]   r_data;
  logic            r_valid;

  modport master (output req, add, wen, be, data, user, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, user, output gnt, r_data, r_valid);
endinterface

// File: rtl/hci_split_rotate.sv
// Lane-to-bank rotation and per-bank word address for a wide access.
// Latency: purely combinational.
// Backpressure: none; pure address decode.
// Ports: add (wide byte address) -> lane_bank (bank per lane), bank_lane (lane per bank),
//        bank_used (bank carries an active lane), bank_word (word address seen by each bank).
module hci_split_rotate #(
  parameter int NB_OUT_CHAN = 8,
  parameter int NB_LANE     = 4,
  parameter int AWH         = 32,
  parameter int AWM         = 12,
  localparam int BW         = $clog2(NB_OUT_CHAN),
  localparam int LW         = (NB_LANE > 1) ? $clog2(NB_LANE) : 1
) (
  input  logic [AWH-1:0]                     add,
  output logic [NB_LANE-1:0][BW-1:0]         lane_bank,
  output logic [NB_OUT_CHAN-1:0][LW-1:0]     bank_lane,
  output logic [NB_OUT_CHAN-1:0]             bank_used,
  output logic [NB_OUT_CHAN-1:0][AWM-1:0]    bank_word
);

  logic [BW-1:0]  bank_off;
  logic [AWM-1:0] word_base;

  assign bank_off  = add[BW+1:2];
  assign word_base = add[AWM+BW+1:BW+2];

  // Byte offset and address bits above the bank word are not part of the bank address.
  logic unused_add;
  if (AWM + BW + 2 < AWH) begin : g_hi_unused
    assign unused_add = ^{add[1:0], add[AWH-1:AWM+BW+2]};
  end else begin : g_hi_none
    assign unused_add = ^add[1:0];
  end

  always_comb begin
    logic [BW-1:0] diff;
    logic          wrap;
    diff      = '0;
    wrap      = 1'b0;
    lane_bank = '0;
    bank_lane = '0;
    bank_used = '0;
    bank_word = '0;
    // Bank count is a power of two, so truncation to BW bits is the modulo.
    for (int k = 0; k < NB_LANE; k++) begin
      lane_bank[k] = bank_off + BW'(k);
    end
    // Inverse view: which lane lands on bank b. A lane wrapped past the last bank
    // exactly when its bank index ended up below bank_off, and then sees the next word.
    for (int b = 0; b < NB_OUT_CHAN; b++) begin
      diff         = BW'(b) - bank_off;
      wrap         = (BW'(b) < bank_off);
      bank_used[b] = (int'(diff) < NB_LANE);
      bank_lane[b] = LW'(diff);
      bank_word[b] = word_base + AWM'(wrap);
    end
  end

endmodule

// File: rtl/hci_hwpe_split_interconnect.sv
// Splits one wide HWPE access into NB_LANE 32-bit bank accesses and merges the responses.
// Latency: in.gnt combinational with the last bank grant; in.r_valid in the cycle the last bank responds.
// Backpressure: in.gnt held low until every active lane is granted; one wide transaction outstanding.
// Ports: clk_i, rst_i (sync, active high), clear_i (sync soft clear), in (wide slave), out[] (bank masters).
// Optional: define HCI_SPLIT_BE_SKIP_EN to skip lanes whose byte-enable slice is all zero.
module hci_hwpe_split_interconnect
  import hci_package::*;
#(
  parameter int NB_OUT_CHAN = 8,
  parameter int DWH         = 128,
  parameter int AWH         = 32,
  parameter int AWM         = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  hci_core_intf.slave in,
  hci_mem_intf.master out [NB_OUT_CHAN]
);

  localparam int NB_LANE = DWH / 32;
  localparam int BW      = $clog2(NB_OUT_CHAN);
  localparam int LW      = (NB_LANE > 1) ? $clog2(NB_LANE) : 1;

  if ((NB_LANE > NB_OUT_CHAN) || (DWH % 32 != 0) || (AWM + BW + 2 > AWH) ||
      (NB_OUT_CHAN < 2) || ((NB_OUT_CHAN & (NB_OUT_CHAN - 1)) != 0) ||
      (NB_LANE > HCI_MAX_LANES)) begin : g_bad_cfg
    $error("hci_hwpe_split_interconnect: unsupported parameter combination");
  end

  split_state_e state_q, state_d;
  lane_mask_t   granted_q, granted_d;
  lane_mask_t   rvalid_q, rvalid_d;
  lane_mask_t   act, act_q;
  lane_mask_t   issue, lane_gnt, gnt_now, lane_rv;
  logic         in_gnt, covered, resp_done;
  logic         hold_q, blank;

  logic [NB_LANE-1:0][BW-1:0]      lane_bank, lane_bank_q;
  logic [NB_OUT_CHAN-1:0][LW-1:0]  bank_lane;
  logic [NB_OUT_CHAN-1:0]          bank_used;
  logic [NB_OUT_CHAN-1:0][AWM-1:0] bank_word;
  logic [NB_OUT_CHAN-1:0]          bank_gnt, bank_rvalid, bank_req;
  logic [NB_OUT_CHAN-1:0][31:0]    bank_rdata;
  logic [NB_LANE-1:0][31:0]        buf_q;
  logic [DWH-1:0]                  r_data_w;

  hci_split_rotate #(
    .NB_OUT_CHAN (NB_OUT_CHAN),
    .NB_LANE     (NB_LANE),
    .AWH         (AWH),
    .AWM         (AWM)
  ) u_rotate (
    .add       (in.add),
    .lane_bank (lane_bank),
    .bank_lane (bank_lane),
    .bank_used (bank_used),
    .bank_word (bank_word)
  );

  for (genvar b = 0; b < NB_OUT_CHAN; b++) begin : g_bank
    assign bank_gnt[b]    = out[b].gnt;
    assign bank_rvalid[b] = out[b].r_valid;
    assign bank_rdata[b]  = out[b].r_data;
    assign out[b].req     = bank_req[b];
    assign out[b].add     = {bank_word[b], 2'b00};
    assign out[b].wen     = in.wen;
    assign out[b].be      = in.be[bank_lane[b]*4 +: 4];
    assign out[b].data    = in.data[bank_lane[b]*32 +: 32];
    assign out[b].user    = 1'b0;
  end

  // Outputs stay quiet in the reset/clear cycle and the one after it, even with in.req held.
  assign blank = rst_i | clear_i | hold_q;

  always_comb begin
    act = '0;
`ifdef HCI_SPLIT_BE_SKIP_EN
    for (int k = 0; k < NB_LANE; k++) act[k] = |in.be[4*k +: 4];
`else
    for (int k = 0; k < NB_LANE; k++) act[k] = 1'b1;
`endif
  end

  always_comb begin
    lane_gnt  = '0;
    lane_rv   = '0;
    bank_req  = '0;
    r_data_w  = '0;
    issue     = '0;
    if (in.req && (state_q != RESP) && !blank) issue = act & ~granted_q;
    for (int k = 0; k < NB_LANE; k++) lane_gnt[k] = bank_gnt[lane_bank[k]];
    // Only grants on lanes actually requesting this cycle count towards completion.
    gnt_now = lane_gnt & issue;
    covered = (((granted_q | gnt_now) & act) == act);
    in_gnt  = in.req && (state_q != RESP) && !blank && covered;
    for (int b = 0; b < NB_OUT_CHAN; b++) bank_req[b] = bank_used[b] && issue[bank_lane[b]];
    // Responses are taken only in RESP, and only once per lane.
    for (int k = 0; k < NB_LANE; k++) begin
      lane_rv[k] = (state_q == RESP) && !blank && act_q[k] && !rvalid_q[k] &&
                   bank_rvalid[lane_bank_q[k]];
    end
    resp_done = (state_q == RESP) && !blank && (((rvalid_q | lane_rv) & act_q) == act_q);
    if (resp_done) begin
      for (int k = 0; k < NB_LANE; k++) begin
        if (act_q[k]) r_data_w[32*k +: 32] = lane_rv[k] ? bank_rdata[lane_bank_q[k]] : buf_q[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    granted_d = granted_q;
    rvalid_d  = rvalid_q;
    case (state_q)
      IDLE, ISSUE: begin
        if (in_gnt) begin
          state_d   = RESP;
          granted_d = '0;
        end else if (in.req && !blank) begin
          state_d   = ISSUE;
          granted_d = granted_q | gnt_now;
        end
      end
      RESP: begin
        if (resp_done) begin
          state_d  = IDLE;
          rvalid_d = '0;
        end else begin
          rvalid_d = rvalid_q | lane_rv;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= IDLE;
      granted_q   <= '0;
      rvalid_q    <= '0;
      act_q       <= '0;
      lane_bank_q <= '0;
      buf_q       <= '0;
      hold_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      granted_q <= granted_d;
      rvalid_q  <= rvalid_d;
      hold_q    <= 1'b0;
      // Lane mapping and mask are frozen at the wide grant; in.add/in.be may change afterwards.
      if (in_gnt) begin
        act_q       <= act;
        lane_bank_q <= lane_bank;
      end
      for (int k = 0; k < NB_LANE; k++) begin
        if (lane_rv[k]) buf_q[k] <= bank_rdata[lane_bank_q[k]];
      end
    end
  end

  assign in.gnt     = in_gnt;
  assign in.r_valid = resp_done;
  assign in.r_data  = r_data_w;
  assign in.r_user  = 1'b0;

endmodule

// File: tb/tb_hci_hwpe_split_interconnect.sv
module tb_hci_hwpe_split_interconnect;
  localparam int NB  = 8;
  localparam int DWH = 128;
  localparam int AWH = 32;
  localparam int AWM = 12;
  localparam int NL  = DWH / 32;

  logic clk = 1'b0;
  logic rst, clr;
  always #5 clk = ~clk;

  hci_core_intf #(.DW(DWH), .AW(AWH))  in_if ();
  hci_mem_intf  #(.DW(32), .AW(AWM+2)) out_if [NB] ();

  hci_hwpe_split_interconnect #(
    .NB_OUT_CHAN (NB), .DWH (DWH), .AWH (AWH), .AWM (AWM)
  ) dut (
    .clk_i (clk), .rst_i (rst), .clear_i (clr), .in (in_if), .out (out_if)
  );

  logic [NB-1:0]            b_req, b_wen, b_user;
  logic [NB-1:0][AWM+1:0]   b_add;
  logic [NB-1:0][3:0]       b_be;
  logic [NB-1:0][31:0]      b_data;
  logic [NB-1:0]            tb_gnt = '0;
  logic [NB-1:0]            tb_rv = '0;
  logic [NB-1:0]            stray_rv = '0;
  logic [NB-1:0][31:0]      tb_rdata = '0;

  for (genvar b = 0; b < NB; b++) begin : g_b
    assign b_req[b]  = out_if[b].req;
    assign b_wen[b]  = out_if[b].wen;
    assign b_user[b] = out_if[b].user;
    assign b_add[b]  = out_if[b].add;
    assign b_be[b]   = out_if[b].be;
    assign b_data[b] = out_if[b].data;
    assign out_if[b].gnt     = tb_gnt[b];
    assign out_if[b].r_valid = tb_rv[b] | stray_rv[b];
    assign out_if[b].r_data  = tb_rdata[b];
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] salt;
  int gnt_wait[NB];
  int rdly[NB];
  bit flush_bank = 0;

  // Bank contents: a fixed scramble of (bank, word) so wrong addressing shows up as wrong data.
  function automatic logic [31:0] mem_word(input int b, input int w);
    return salt ^ (32'(b) << 28) ^ (32'(w) * 32'h9E3779B1);
  endfunction

  // Bank model: a granted bank holds its read data and answers rdly cycles after the wide grant.
  bit          armed[NB];
  int          cnt[NB];
  logic [31:0] pdata[NB];
  initial for (int b = 0; b < NB; b++) begin armed[b] = 0; cnt[b] = 0; pdata[b] = '0; end

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (b_req[b] && tb_gnt[b]) begin
        armed[b] = 1;
        pdata[b] = mem_word(b, int'(b_add[b][AWM+1:2]));
      end
    end
    if (in_if.gnt === 1'b1)
      for (int b = 0; b < NB; b++) if (armed[b]) begin cnt[b] = rdly[b]; armed[b] = 0; end
    if (flush_bank)
      for (int b = 0; b < NB; b++) begin armed[b] = 0; cnt[b] = 0; end
    #1;
    for (int b = 0; b < NB; b++) begin
      tb_rv[b] = 1'b0;
      if (cnt[b] == 1) begin tb_rv[b] = 1'b1; tb_rdata[b] = pdata[b]; cnt[b] = 0; end
      else if (cnt[b] > 1) cnt[b]--;
    end
  end

  task automatic set_timing(input int gw, input int rd);
    for (int b = 0; b < NB; b++) begin gnt_wait[b] = gw; rdly[b] = rd; end
  endtask

  // Drives one wide access and checks it against the interleaved-memory reference.
  task automatic run_txn(input logic [31:0] addr, input logic [15:0] be, input logic wen,
                         input logic [127:0] wdata, input string tag);
    int lb[NL];
    int lw[NL];
    logic [NL-1:0]  act;
    logic [NB-1:0]  exp_req;
    logic [127:0]   exp_rd;
    int exp_gc, maxr, gc, g;
    bit got, bad;
    exp_gc = 0; maxr = 1; gc = 0; exp_rd = '0;
    for (int k = 0; k < NL; k++) begin
      g = int'(addr >> 2) + k;
      lb[k] = g % NB;
      lw[k] = (g / NB) % (1 << AWM);
`ifdef HCI_SPLIT_BE_SKIP_EN
      act[k] = |be[4*k +: 4];
`else
      act[k] = 1'b1;
`endif
    end
    for (int k = 0; k < NL; k++) if (act[k]) begin
      if (gnt_wait[lb[k]] > exp_gc) exp_gc = gnt_wait[lb[k]];
      if (k == 0 || rdly[lb[k]] > maxr) maxr = rdly[lb[k]];
      exp_rd[32*k +: 32] = mem_word(lb[k], lw[k]);
    end
    for (int k = 0; k < NL; k++) if (act[k] && rdly[lb[k]] > maxr) maxr = rdly[lb[k]];

    @(posedge clk); #1;
    in_if.req = 1'b1; in_if.add = addr; in_if.be = be; in_if.wen = wen; in_if.data = wdata;
    got = 0;
    for (int c = 0; c <= 40 && !got; c++) begin
      for (int b = 0; b < NB; b++) tb_gnt[b] = (c >= gnt_wait[b]);
      @(negedge clk);
      exp_req = '0;
      for (int k = 0; k < NL; k++) if (act[k] && c <= gnt_wait[lb[k]]) exp_req[lb[k]] = 1'b1;
      n_checks++;
      if (b_req !== exp_req) begin
        n_fail++; $display("FAIL %s bank_req c=%0d got=%b exp=%b", tag, c, b_req, exp_req);
      end
      bad = 0;
      for (int k = 0; k < NL; k++) if (exp_req[lb[k]] && act[k]) begin
        if (b_add[lb[k]] !== {AWM'(lw[k]), 2'b00} || b_be[lb[k]] !== be[4*k +: 4] ||
            b_wen[lb[k]] !== wen || b_data[lb[k]] !== wdata[32*k +: 32]) bad = 1;
      end
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL %s bank_fields c=%0d got=bad exp=ok", tag, c); end
      n_checks++;
      if (in_if.gnt !== (c == exp_gc)) begin
        n_fail++; $display("FAIL %s in_gnt c=%0d got=%b exp=%b", tag, c, in_if.gnt, c == exp_gc);
      end
      if (in_if.gnt === 1'b1) begin got = 1; gc = c; end
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s gnt_timeout got=none exp=c%0d", tag, exp_gc);
      @(posedge clk); #1; in_if.req = 1'b0; tb_gnt = '0;
      return;
    end
    @(posedge clk); #1;
    in_if.req = 1'b0; tb_gnt = '0;
    got = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      n_checks++;
      if (b_req !== '0) begin n_fail++; $display("FAIL %s resp_req got=%b exp=0", tag, b_req); end
      if (in_if.r_valid === 1'b1) begin
        got = 1;
        n_checks++;
        if (gc + c != exp_gc + maxr) begin
          n_fail++; $display("FAIL %s rvalid_cycle got=%0d exp=%0d", tag, gc + c, exp_gc + maxr);
        end
        n_checks++;
        if (in_if.r_data !== exp_rd) begin
          n_fail++; $display("FAIL %s r_data got=%h exp=%h", tag, in_if.r_data, exp_rd);
        end
      end else begin
        @(posedge clk);
      end
    end
    if (!got) begin
      n_checks++; n_fail++; $display("FAIL %s rvalid_timeout got=none exp=pulse", tag);
      return;
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (in_if.r_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s rvalid_single got=%b exp=0", tag, in_if.r_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; tb_gnt = '1;
    in_if.req = 1'b1; in_if.add = '0; in_if.be = '1; in_if.wen = 1'b1; in_if.data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_if.gnt !== 1'b0 || in_if.r_valid !== 1'b0 || in_if.r_data !== '0 || b_req !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=gnt%b rv%b req%b exp=all0", in_if.gnt, in_if.r_valid, b_req);
    end
    n_checks++;
    if (in_if.r_user !== 1'b0 || b_user !== '0) begin
      n_fail++; $display("FAIL reset_user got=%b/%b exp=0", in_if.r_user, b_user);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_if.gnt !== 1'b0 || b_req !== '0 || in_if.r_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_quiet got=gnt%b req%b exp=0", in_if.gnt, b_req);
    end
    @(posedge clk); #1; in_if.req = 1'b0; tb_gnt = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_aligned();
    set_timing(0, 1);
    run_txn(32'h0, 16'hFFFF, 1'b1, {$urandom, $urandom, $urandom, $urandom}, "aligned");
  endtask

  task automatic test_wrap();
    set_timing(0, 1);
    run_txn(32'h18, 16'hFFFF, 1'b1, {$urandom, $urandom, $urandom, $urandom}, "wrap");
    run_txn(32'h3C, 16'hFFFF, 1'b0, {$urandom, $urandom, $urandom, $urandom}, "wrap_write");
    run_txn(32'h0001_FFF8, 16'hFFFF, 1'b1, 128'h0, "word_wrap");
  endtask

  task automatic test_staggered();
    set_timing(0, 1);
    gnt_wait[2] = 3;
    run_txn(32'h0, 16'hFFFF, 1'b1, {$urandom, $urandom, $urandom, $urandom}, "staggered");
  endtask

  task automatic test_skewed();
    set_timing(0, 1);
    rdly[0] = 1; rdly[1] = 2; rdly[2] = 2; rdly[3] = 4;
    run_txn(32'h0, 16'hFFFF, 1'b1, 128'h0, "skewed");
  endtask

  task automatic test_stray();
    @(posedge clk); #1; stray_rv = '1;
    @(negedge clk);
    n_checks++;
    if (in_if.r_valid !== 1'b0) begin n_fail++; $display("FAIL stray_rvalid got=%b exp=0", in_if.r_valid); end
    @(posedge clk); #1; stray_rv = '0;
    @(negedge clk);
    n_checks++;
    if (in_if.r_valid !== 1'b0) begin n_fail++; $display("FAIL stray_after got=%b exp=0", in_if.r_valid); end
  endtask

  task automatic test_abort(input bit use_clear);
    bit seen;
    set_timing(0, 1);
    gnt_wait[2] = 99; gnt_wait[3] = 99;
    @(posedge clk); #1;
    in_if.req = 1'b1; in_if.add = '0; in_if.be = '1; in_if.wen = 1'b1; in_if.data = '0;
    for (int b = 0; b < NB; b++) tb_gnt[b] = (gnt_wait[b] == 0);
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (b_req !== 8'b0000_1100) begin
      n_fail++; $display("FAIL abort_partial clr=%0d got=%b exp=00001100", use_clear, b_req);
    end
    @(posedge clk); #1;
    if (use_clear) clr = 1'b1; else rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (b_req !== '0 || in_if.gnt !== 1'b0 || in_if.r_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_cycle clr=%0d got=req%b gnt%b exp=0", use_clear, b_req, in_if.gnt);
    end
    @(posedge clk); #1;
    clr = 1'b0; rst = 1'b0; flush_bank = 1; tb_gnt = '1;
    @(negedge clk);
    n_checks++;
    if (b_req !== '0 || in_if.gnt !== 1'b0) begin
      n_fail++; $display("FAIL abort_next clr=%0d got=req%b gnt%b exp=0", use_clear, b_req, in_if.gnt);
    end
    @(posedge clk); #1; in_if.req = 1'b0; tb_gnt = '0; flush_bank = 0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (in_if.r_valid !== 1'b0) seen = 1; end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL abort_no_rvalid clr=%0d got=pulse exp=none", use_clear); end
    set_timing(0, 1);
    run_txn(32'h24, 16'hFFFF, 1'b1, 128'h0, use_clear ? "after_clear" : "after_reset");
  endtask

  task automatic test_be_patterns();
    set_timing(0, 1);
    run_txn(32'h0, 16'h00F0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, "be_00f0");
    run_txn(32'h0, 16'h0000, 1'b1, 128'h0, "be_0000");
    gnt_wait[5] = 2;
    run_txn(32'h10, 16'hF00F, 1'b1, 128'h0, "be_f00f");
  endtask

  task automatic test_random();
    logic [15:0] be;
    for (int i = 0; i < 24; i++) begin
      for (int b = 0; b < NB; b++) begin
        gnt_wait[b] = $urandom_range(0, 3);
        rdly[b]     = $urandom_range(1, 4);
      end
      be = 16'($urandom);
      if (i % 4 == 0) be = 16'hFFFF;
      run_txn({$urandom} & 32'hFFFF_FFFC, be, 1'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, "random");
    end
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_aligned();
    test_wrap();
    test_staggered();
    test_skewed();
    test_stray();
    test_abort(1'b0);
    test_abort(1'b1);
    test_be_patterns();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hci_hwpe_split_interconnect.md
HCI_HWPE_SPLIT_INTERCONNECT -- requirements
Module: hci_hwpe_split_interconnect

Interface
REQ-001 Parameters SHALL be one per line as follows.
- NB_OUT_CHAN, 8: number of 32-bit memory banks.
- DWH, 128: wide port data width, a multiple of 32.
- AWH, 32: wide port address width.
- AWM, 12: per-bank word-address width.
REQ-002 Derived constant NB_LANE = DWH/32; elaboration SHALL fail if NB_LANE > NB_OUT_CHAN, DWH%32 != 0, or AWM+log2(NB_OUT_CHAN)+2 > AWH.
REQ-003 Ports SHALL be, in order:
- clk_i, input, 1: sole clock.
- rst_i, input, 1: synchronous active-high reset.
- clear_i, input, 1: synchronous soft clear.
- in, hci_core_intf.slave, DWH: wide HWPE port.
- out, hci_mem_intf.master array [NB_OUT_CHAN], 32: bank ports.

Function
REQ-004 Lane k (0..NB_LANE-1) SHALL map to bank (bank_off+k) mod NB_OUT_CHAN, where bank_off = in.add[log2(NB_OUT_CHAN)+1:2].
REQ-005 Lane word address SHALL be in.add[AWM+log2(NB_OUT_CHAN)+1 : log2(NB_OUT_CHAN)+2], incremented by 1 (modulo 2^AWM, no carry out) when bank_off+k >= NB_OUT_CHAN; out.add SHALL be that word address followed by 2'b00.
REQ-006 Active lane mask act = all NB_LANE lanes (see REQ-016 for the alternative); banks not mapped to an active lane SHALL drive req=0.
REQ-007 FSM states SHALL be IDLE, ISSUE and RESP; reset state is IDLE.
REQ-008 IDLE/ISSUE behaviour:
- With in.req=1, every active lane not yet in granted_q SHALL drive out.req=1 with wen, be slice and data slice from in.
- Granted lanes SHALL drop out.req in the cycle after their grant.
REQ-009 in.gnt SHALL be combinational and equal 1 exactly in the cycle where (granted_q | current out.gnt over act) covers act.
- On that cycle the FSM SHALL go to RESP and granted_q SHALL be cleared.
- Otherwise the FSM SHALL go or stay in ISSUE, with granted_q accumulating grants.
REQ-010 Bank grants SHALL be independent; partial grants SHALL never be reissued.
REQ-011 In RESP, in.gnt SHALL be 0 and out.req SHALL be 0.
- Each lane's out.r_valid SHALL set rvalid_q[k] and capture out.r_data into buf[k].
REQ-012 in.r_valid SHALL pulse for exactly one cycle, when (rvalid_q | live r_valid) covers act.
- in.r_data lane k SHALL be live data if arriving that cycle, else buf[k].
- Inactive lanes SHALL read 0.
- The FSM SHALL then return to IDLE.
REQ-013 Latency: all lanes granted at cycle t and all banks respond at t+1 gives in.gnt at t and in.r_valid at t+1. The block SHALL support one outstanding wide transaction at a time.
REQ-014 Bank r_valid outside RESP, or on an already-set lane, SHALL be ignored.
REQ-015 clear_i SHALL act like reset on the FSM, granted_q, rvalid_q and buf, and SHALL take priority over all events in the same cycle. in.r_user and out.user SHALL be tied to 0.

Configuration
REQ-016 With macro HCI_SPLIT_BE_SKIP_EN defined, a lane SHALL be in act only if its 4-bit be slice is nonzero (reads included).
- If act is empty, in.gnt SHALL assert immediately and in.r_valid SHALL follow the next cycle with zero data, with no bank access.
- Without the macro, act SHALL be all lanes.

Reset
REQ-017 On rst_i=1 at a clk_i edge, all state SHALL take its reset value:
- FSM = IDLE; granted_q, rvalid_q and buf = 0.
- Outputs in.gnt, in.r_valid, in.r_data and all out.req SHALL be 0 in that cycle and the next.
REQ-018 A reset mid-transaction SHALL discard all pending grants and responses without producing in.r_valid.

Structure
REQ-019 The FSM state enum and the lane-mask typedef SHALL live in hci_package.
REQ-020 Lane-to-bank rotation and address increment SHALL be one sub-module, hci_split_rotate (combinational). FSM, trackers and buffer SHALL stay in the top module.

Verification
REQ-021 Aligned read:
- Stimulus: DWH=128, NB_OUT_CHAN=8, add=0x0, all banks grant immediately.
- Response: banks 0-3 req at t, in.gnt at t, in.r_valid at t+1, data concatenated lane0 lowest.
REQ-022 Wrap read:
- Stimulus: add=0x18 (bank_off=6).
- Response: lanes 0-1 go to banks 6-7 with word 0; lanes 2-3 go to banks 0-1 with word 1.
REQ-023 Staggered grant:
- Stimulus: bank 2 grant withheld for 3 cycles.
- Response: banks 0,1,3 req drop after t; in.gnt at t+3; single in.r_valid after the last bank response.
REQ-024 Skewed responses:
- Stimulus: bank responses arrive at t+1, t+2, t+2, t+4.
- Response: exactly one in.r_valid at t+4 with correct buffered data.
REQ-025 Reset/clear:
- Stimulus: rst_i, then separately clear_i, asserted in ISSUE with 2 of 4 lanes granted.
- Response: next cycle IDLE, no out.req, no in.r_valid; a fresh request completes normally.
REQ-026 HCI_SPLIT_BE_SKIP_EN:
- Stimulus: be=16'h00F0.
- Response: only lane 1 bank requested; be=16'h0000 gives gnt at t and r_valid=1 with data 0 at t+1, no bank req.
